// File: rtl/pci_arbiter.sv
// pci_arbiter: round-robin PCI REQ/GNT arbiter with unused-grant timeout
module pci_arbiter #(
    parameter int NUM_DEV       = 3,
    parameter int START_TIMEOUT = 16,
    parameter int IDX_W         = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_DEV-1:0] REQ,
    output logic [NUM_DEV-1:0] GNT,
    input  logic               FRAME,
    input  logic               IRDY,
    output logic               gnt_valid,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               bus_busy,
    output logic               timeout
);
    typedef enum logic [1:0] {IDLE, GRANTED, BUSY} state_t;

    state_t               state, state_n;
    logic [NUM_DEV-1:0]   req_act, gnt_n;
    logic                 frame_act, irdy_act, bus_idle;
    logic                 valid_n, busy_n, to_n;
    logic [IDX_W-1:0]     idx_n, win, j;
    logic [7:0]           cnt, cnt_n;

    // Only a solid 0 counts as asserted; floating or unknown lines read as released
    always_comb begin
        for (int i = 0; i < NUM_DEV; i++) req_act[i] = (REQ[i] === 1'b0);
        frame_act = (FRAME === 1'b0);
        irdy_act  = (IRDY === 1'b0);
        bus_idle  = !frame_act && !irdy_act;
    end

    // Round-robin pick: first requester after the last owner, scanned backwards so the nearest wins
    always_comb begin
        win = gnt_idx;
        j   = gnt_idx;
        for (int k = NUM_DEV; k >= 1; k--) begin
            j = IDX_W'((int'(gnt_idx) + k) % NUM_DEV);
            if (req_act[j]) win = j;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_n = state;
        gnt_n   = GNT;
        valid_n = gnt_valid;
        idx_n   = gnt_idx;
        busy_n  = bus_busy;
        to_n    = 1'b0;
        cnt_n   = cnt;
        case (state)
            IDLE: if (bus_idle && |req_act) begin
                gnt_n   = ~(NUM_DEV'(1) << win);
                idx_n   = win;
                valid_n = 1'b1;
                cnt_n   = 8'd0;
                state_n = GRANTED;
            end
            GRANTED: if (frame_act) begin
                busy_n  = 1'b1;
                state_n = BUSY;
            end else if (!req_act[gnt_idx] || cnt == 8'(START_TIMEOUT - 1)) begin
                gnt_n   = '1;
                valid_n = 1'b0;
                to_n    = req_act[gnt_idx];
                state_n = IDLE;
            end else begin
                cnt_n = cnt + 8'd1;
            end
            BUSY: if (bus_idle) begin
                gnt_n   = '1;
                valid_n = 1'b0;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            GNT       <= '1;
            gnt_valid <= 1'b0;
            gnt_idx   <= IDX_W'(NUM_DEV - 1);
            bus_busy  <= 1'b0;
            timeout   <= 1'b0;
            cnt       <= 8'd0;
        end else begin
            state     <= state_n;
            GNT       <= gnt_n;
            gnt_valid <= valid_n;
            gnt_idx   <= idx_n;
            bus_busy  <= busy_n;
            timeout   <= to_n;
            cnt       <= cnt_n;
        end
    end
endmodule

// File: tb/tb_pci_arbiter.sv
// tb_pci_arbiter: directed vector table plus hand sequences for the timeout corners
module tb_pci_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] req = 3'b111;
    logic       frame = 1'b1, irdy = 1'b1;
    logic [2:0] gnt;
    logic       gnt_valid, bus_busy, timeout;
    logic [1:0] gnt_idx;
    int         n_run = 0, n_fail = 0;

    typedef struct {
        logic       rst;
        logic [2:0] req;
        logic       frame;
        logic       irdy;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vq[$];

    pci_arbiter #(.NUM_DEV(3), .START_TIMEOUT(16), .IDX_W(2)) dut (
        .clk(clk), .rst(rst), .REQ(req), .GNT(gnt), .FRAME(frame), .IRDY(irdy),
        .gnt_valid(gnt_valid), .gnt_idx(gnt_idx), .bus_busy(bus_busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] o(logic [2:0] g, logic v, logic [1:0] ix, logic b, logic t);
        return {g, v, ix, b, t};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [7:0] exp);
        logic [7:0] act;
        act = {gnt, gnt_valid, gnt_idx, bus_busy, timeout};
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: {gnt,valid,idx,busy,to} got %b expected %b", name, act, exp);
        end
    endtask

    task automatic add(string nm, logic r, logic [2:0] q, logic f, logic i, logic [7:0] e);
        vq.push_back('{r, q, f, i, e, nm});
    endtask

    initial begin
        add("reset",        1, 3'b111, 1, 1, o(3'b111, 0, 2'd2, 0, 0));
        add("single_grant", 0, 3'b101, 1, 1, o(3'b101, 1, 2'd1, 0, 0));
        add("single_frame", 0, 3'b101, 0, 1, o(3'b101, 1, 2'd1, 1, 0));
        add("single_data",  0, 3'b111, 0, 0, o(3'b101, 1, 2'd1, 1, 0));
        add("single_last",  0, 3'b111, 1, 0, o(3'b101, 1, 2'd1, 1, 0));
        add("single_rel",   0, 3'b111, 1, 1, o(3'b111, 0, 2'd1, 0, 0));
        add("cont_reset",   1, 3'b000, 1, 1, o(3'b111, 0, 2'd2, 0, 0));
        add("cont_g0",      0, 3'b000, 1, 1, o(3'b110, 1, 2'd0, 0, 0));
        add("cont_f0",      0, 3'b000, 0, 1, o(3'b110, 1, 2'd0, 1, 0));
        add("cont_d0",      0, 3'b000, 0, 0, o(3'b110, 1, 2'd0, 1, 0));
        add("cont_l0",      0, 3'b000, 1, 0, o(3'b110, 1, 2'd0, 1, 0));
        add("cont_r0",      0, 3'b000, 1, 1, o(3'b111, 0, 2'd0, 0, 0));
        add("cont_g1",      0, 3'b000, 1, 1, o(3'b101, 1, 2'd1, 0, 0));
        add("cont_d1",      0, 3'b000, 0, 0, o(3'b101, 1, 2'd1, 1, 0));
        add("cont_l1",      0, 3'b000, 1, 0, o(3'b101, 1, 2'd1, 1, 0));
        add("cont_r1",      0, 3'b000, 1, 1, o(3'b111, 0, 2'd1, 0, 0));
        add("cont_g2",      0, 3'b000, 1, 1, o(3'b011, 1, 2'd2, 0, 0));
        add("cont_d2",      0, 3'b000, 0, 0, o(3'b011, 1, 2'd2, 1, 0));
        add("cont_l2",      0, 3'b000, 1, 0, o(3'b011, 1, 2'd2, 1, 0));
        add("cont_r2",      0, 3'b000, 1, 1, o(3'b111, 0, 2'd2, 0, 0));
        add("cont_g0b",     0, 3'b000, 1, 1, o(3'b110, 1, 2'd0, 0, 0));
        add("drop_owner",   0, 3'b111, 1, 1, o(3'b111, 0, 2'd0, 0, 0));
        add("early_g2",     0, 3'b010, 1, 1, o(3'b011, 1, 2'd2, 0, 0));
        add("early_w1",     0, 3'b010, 1, 1, o(3'b011, 1, 2'd2, 0, 0));
        add("early_w2",     0, 3'b010, 1, 1, o(3'b011, 1, 2'd2, 0, 0));
        add("early_rel",    0, 3'b110, 1, 1, o(3'b111, 0, 2'd2, 0, 0));
        add("early_g0",     0, 3'b110, 1, 1, o(3'b110, 1, 2'd0, 0, 0));
        add("rwb_frame",    0, 3'b110, 0, 1, o(3'b110, 1, 2'd0, 1, 0));
        add("rwb_req1",     0, 3'b100, 0, 0, o(3'b110, 1, 2'd0, 1, 0));
        add("rwb_last",     0, 3'b100, 1, 0, o(3'b110, 1, 2'd0, 1, 0));
        add("rwb_rel",      0, 3'b100, 1, 1, o(3'b111, 0, 2'd0, 0, 0));
        add("rwb_g1",       0, 3'b101, 1, 1, o(3'b101, 1, 2'd1, 0, 0));
        add("rmt_busy",     0, 3'b101, 0, 1, o(3'b101, 1, 2'd1, 1, 0));
        add("rmt_reset",    1, 3'b101, 0, 0, o(3'b111, 0, 2'd2, 0, 0));
        add("rmt_frame0",   0, 3'b101, 0, 0, o(3'b111, 0, 2'd2, 0, 0));
        add("rmt_frame1",   0, 3'b101, 0, 1, o(3'b111, 0, 2'd2, 0, 0));
        add("rmt_idle_g1",  0, 3'b101, 1, 1, o(3'b101, 1, 2'd1, 0, 0));
        add("hold_count",   0, 3'b101, 1, 1, o(3'b101, 1, 2'd1, 0, 0));
        add("rel_no_to",    0, 3'b111, 1, 1, o(3'b111, 0, 2'd1, 0, 0));

        foreach (vq[k]) begin
            rst = vq[k].rst; req = vq[k].req; frame = vq[k].frame; irdy = vq[k].irdy;
            step();
            chk(vq[k].name, vq[k].exp);
        end

        rst = 1; req = 3'b110; frame = 1; irdy = 1;
        step();
        chk("to_reset", o(3'b111, 0, 2'd2, 0, 0));
        rst = 0;
        step();
        chk("to_grant", o(3'b110, 1, 2'd0, 0, 0));
        for (int c = 1; c < 16; c++) begin
            step();
            chk($sformatf("to_hold%0d", c), o(3'b110, 1, 2'd0, 0, 0));
        end
        step();
        chk("to_revoke", o(3'b111, 0, 2'd0, 0, 1));
        step();
        chk("to_regrant", o(3'b110, 1, 2'd0, 0, 0));
        for (int c = 1; c < 16; c++) step();
        chk("to_pre_edge", o(3'b110, 1, 2'd0, 0, 0));
        frame = 0;
        step();
        chk("to_frame_wins", o(3'b110, 1, 2'd0, 1, 0));
        frame = 1; req = 3'b111;
        step();
        chk("to_final_rel", o(3'b111, 0, 2'd0, 0, 0));
        step();
        chk("to_quiet", o(3'b111, 0, 2'd0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
